window_sad_fetch: RTL and testbench

//  Downstream of the 16-address target adder. Takes one target-window base address, walks its 16

---
 rtl/window_sad_fetch.sv | 67 ++++++
 tb/tb_window_sad_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/window_sad_fetch.sv
// window_sad_fetch: walks the 16 words of a frame window against the template and accumulates one SAD per window.
// Reads have one cycle of latency, so the accumulator runs one cycle behind the read strobe.
module window_sad_fetch #(
    parameter int NUM_WORDS = 16,
    parameter int STRIDE = 4,
    localparam int IW = $clog2(NUM_WORDS)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [31:0]   target_window,
    output logic          frame_rd_en,
    output logic [31:0]   frame_addr,
    input  logic [31:0]   frame_rd_data,
    output logic [IW-1:0] tmpl_addr,
    input  logic [31:0]   tmpl_rd_data,
    output logic [31:0]   sad,
    output logic          sad_valid,
    input  logic          sad_ready
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx;
    logic [31:0] base, acc, mag;
    logic [32:0] diff;
    logic rd_q, accept;
    assign accept = start_valid && start_ready;
    assign diff = {frame_rd_data[31], frame_rd_data} - {tmpl_rd_data[31], tmpl_rd_data};
    assign mag = diff[32] ? ~diff[31:0] + 32'd1 : diff[31:0];
    assign start_ready = state == IDLE;
    assign frame_rd_en = state == FETCH;
    assign frame_addr = frame_rd_en ? base + 32'(STRIDE) * 32'(idx) : 32'd0;
    assign tmpl_addr = frame_rd_en ? idx : '0;
    assign sad_valid = state == DONE;
    // acc is frozen in DONE (no read precedes it), so it can drive sad directly
    assign sad = sad_valid ? acc : 32'd0;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start_valid ? FETCH : IDLE;
            FETCH: state_n = idx == IW'(NUM_WORDS - 1) ? DRAIN : FETCH;
            DRAIN: state_n = DONE;
            DONE:  state_n = sad_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            idx <= '0;
            acc <= '0;
            base <= '0;
            rd_q <= 1'b0;
        end else begin
            state <= state_n;
            rd_q <= frame_rd_en;
            if (frame_rd_en) idx <= idx + 1'b1;
            if (rd_q) acc <= acc + mag;
            if (accept) begin
                base <= target_window;
                acc <= '0;
                idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_window_sad_fetch.sv
// tb_window_sad_fetch: directed checks of window_sad_fetch against a one-cycle-latency memory model.
module tb_window_sad_fetch;
    logic Clk = 0, Reset = 1, start_valid = 0, sad_ready = 1;
    logic [31:0] target_window = 0, frame_rd_data = 0, tmpl_rd_data = 0, sad, frame_addr;
    logic start_ready, frame_rd_en, sad_valid;
    logic [3:0] tmpl_addr;
    logic [31:0] frame_words [16];
    logic [31:0] tmpl_words [16];
    logic [31:0] seen_addr [16];
    logic [31:0] cur_base = 0;
    int cyc = 0, nchk = 0, nerr = 0, acc_cyc = 0, prev_acc = 0;

    window_sad_fetch dut (
        .Clk(Clk), .Reset(Reset), .start_valid(start_valid), .start_ready(start_ready),
        .target_window(target_window), .frame_rd_en(frame_rd_en), .frame_addr(frame_addr),
        .frame_rd_data(frame_rd_data), .tmpl_addr(tmpl_addr), .tmpl_rd_data(tmpl_rd_data),
        .sad(sad), .sad_valid(sad_valid), .sad_ready(sad_ready)
    );

    always #5 Clk = ~Clk;

    // frame memory is addressed relative to the window base the bench issued
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        frame_rd_data <= frame_rd_en ? frame_words[4'((frame_addr - cur_base) >> 2)] : 32'hBAD0BAD0;
        tmpl_rd_data <= frame_rd_en ? tmpl_words[tmpl_addr] : 32'h0BAD0BAD;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // accept a window at the current cycle and step through to the DONE cycle
    task automatic do_window(input logic [31:0] b, input logic [31:0] exp_sad);
        chk("ready_before_accept", 32'(start_ready), 32'd1);
        start_valid = 1;
        target_window = b;
        cur_base = b;
        acc_cyc = cyc;
        tick;
        start_valid = 0;
        target_window = ~b;
        for (int i = 0; i < 16; i++) begin
            chk("rd_en", 32'(frame_rd_en), 32'd1);
            chk("frame_addr", frame_addr, b + 32'(4 * i));
            chk("tmpl_addr", 32'(tmpl_addr), 32'(i));
            chk("busy_ready", 32'(start_ready), 32'd0);
            seen_addr[i] = frame_addr;
            start_valid = (i == 5);
            tick;
        end
        start_valid = 0;
        chk("drain_rd_en", 32'(frame_rd_en), 32'd0);
        chk("drain_valid", 32'(sad_valid), 32'd0);
        tick;
        chk("sad_valid", 32'(sad_valid), 32'd1);
        chk("sad", sad, exp_sad);
        chk("done_ready", 32'(start_ready), 32'd0);
    endtask

    task automatic load_ramp;
        for (int i = 0; i < 16; i++) begin
            frame_words[i] = 32'(i);
            tmpl_words[i] = 32'd0;
        end
    endtask

    initial begin
        // reset with a pending start that must not be taken
        start_valid = 1;
        target_window = 32'h55;
        tick;
        tick;
        chk("rst_ready", 32'(start_ready), 32'd1);
        chk("rst_rd_en", 32'(frame_rd_en), 32'd0);
        chk("rst_addr", frame_addr, 32'd0);
        chk("rst_tmpl", 32'(tmpl_addr), 32'd0);
        chk("rst_sad", sad, 32'd0);
        chk("rst_valid", 32'(sad_valid), 32'd0);
        start_valid = 0;
        Reset = 0;
        tick;
        chk("post_rst_idle", 32'(frame_rd_en), 32'd0);
        // ramp data: sum 0..15 = 120
        load_ramp;
        do_window(32'h100, 32'd120);
        tick;
        chk("back_idle", 32'(start_ready), 32'd1);
        chk("valid_drop", 32'(sad_valid), 32'd0);
        // -5 vs 3: |−8| * 16 = 128
        for (int i = 0; i < 16; i++) begin
            frame_words[i] = 32'hFFFFFFFB;
            tmpl_words[i] = 32'd3;
        end
        do_window(32'h2000, 32'd128);
        tick;
        for (int i = 0; i < 16; i++) begin
            frame_words[i] = (32'(i) * 32'h01010101) ^ 32'h80000000;
            tmpl_words[i] = frame_words[i];
        end
        do_window(32'h3000, 32'd0);
        tick;
        // backpressure in DONE
        load_ramp;
        sad_ready = 0;
        do_window(32'h400, 32'd120);
        for (int k = 0; k < 5; k++) begin
            start_valid = 1;
            tick;
            chk("hold_sad", sad, 32'd120);
            chk("hold_valid", 32'(sad_valid), 32'd1);
            chk("hold_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 0;
        sad_ready = 1;
        tick;
        chk("release_ready", 32'(start_ready), 32'd1);
        chk("release_valid", 32'(sad_valid), 32'd0);
        do_window(32'h500, 32'd120);
        tick;
        // reset in the middle of FETCH
        start_valid = 1;
        target_window = 32'h600;
        cur_base = 32'h600;
        tick;
        start_valid = 0;
        for (int k = 0; k < 7; k++) tick;
        chk("mid_idx", 32'(tmpl_addr), 32'd7);
        Reset = 1;
        tick;
        Reset = 0;
        chk("mid_rst_rd_en", 32'(frame_rd_en), 32'd0);
        chk("mid_rst_valid", 32'(sad_valid), 32'd0);
        chk("mid_rst_ready", 32'(start_ready), 32'd1);
        do_window(32'h100, 32'd120);
        tick;
        // address wrap and back-to-back accepts
        do_window(32'hFFFFFFF0, 32'd120);
        chk("wrap_hi", seen_addr[3], 32'hFFFFFFFC);
        chk("wrap_zero", seen_addr[4], 32'h00000000);
        chk("wrap_last", seen_addr[15], 32'h0000002C);
        prev_acc = acc_cyc;
        tick;
        do_window(32'h700, 32'd120);
        chk("accept_spacing", 32'(acc_cyc - prev_acc), 32'd19);
        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule
